triangle_wave_gen: RTL
======================

// Module: triangle_wave_gen
// PURPOSE
//  Programmable symmetric triangle-wave source, 32-bit signed samples, one sample per enabled clock.
//  Source side of the peak-measurement chain: drives a known peak amplitude into the converter model.
//  Its output feeds the peak detector, so measured peak must equal the programmed amplitude.
//  Amplitude/step updates are staged and applied only at upward zero crossings, so waveform symmetry holds.
// PARAMETERS
//  DATA_W   32  sample width (signed, two's complement)
//  DWELL_W  16  dwell counter width (used only with TRIWAVE_DWELL_EN)
// PORTS
//  i_clock         in   1       system clock, all state on rising edge
//  i_RESET         in   1       asynchronous, active-low reset
//  i_enable        in   1       1: advance one sample per clock; 0: freeze all state
//  i_load          in   1       single-cycle request to stage i_amplitude/i_step
//  i_amplitude     in   DATA_W  signed peak magnitude; values <0 treated as 0
//  i_step          in   DATA_W  signed increment per sample; values <0 treated as 0
//  i_dwell         in   DWELL_W cycles to hold at each peak (only with TRIWAVE_DWELL_EN)
//  o_ready         out  1       1 = no staged update pending, i_load accepted
//  o_data          out  DATA_W  signed sample (registered)
//  o_peak_event    out  1       one-cycle pulse on the cycle o_data reaches +/-amplitude
//  o_peak_positive out  1       polarity of last peak (1 = +amp), valid with o_peak_event
// BEHAVIOUR
//  Reset (async, i_RESET=0): o_data=0, o_peak_event=0, o_peak_positive=0, o_ready=1, state IDLE,
//    active amp/step=0, shadow cleared. Reset mid-waveform aborts immediately, no completion.
//  States: IDLE, RISE, FALL (+ HOLD_HI, HOLD_LO with macro).
//  IDLE: o_data=0; on i_enable=1 -> RISE; pending shadow applied on that same edge.
//  RISE: n = o_data + step in DATA_W+1 bits; n >= amp -> o_data=amp, pulse peak (pos=1), -> FALL;
//    else o_data=n.
//  FALL: n = o_data - step in DATA_W+1 bits; n <= -amp -> o_data=-amp, pulse peak (pos=0), -> RISE;
//    else o_data=n.
//  Arithmetic: 33-bit intermediate, no wrap; output always within [-amp, +amp].
//  Load handshake: i_load && o_ready captures both inputs into shadow, o_ready=0 next cycle;
//    i_load with o_ready=0 is ignored (no queueing).
//  Apply: on edge where o_data goes <0 -> >=0 in RISE, shadow -> active; o_ready=1 next cycle.
//    That edge's sample uses old step.
//  Apply and peak on the same edge: both take effect; peak compare uses old amp.
//  New amp < |o_data| after apply: next RISE compare clamps to new amp on the following edge.
//  amp=0: output stays 0, peak_event pulses each enabled cycle, alternating polarity.
//  step=0: output holds; no peak unless |o_data| already equals amp.
//  i_enable=0: o_data, state and counters hold; o_peak_event=0; load handshake still active.
//  Latency: i_enable rise -> first nonzero sample 1 clock after leaving IDLE.
// CONFIGURATION
//  TRIWAVE_DWELL_EN defined:
//    on peak, enter HOLD_HI/HOLD_LO, hold o_data for i_dwell enabled cycles, then FALL/RISE.
//    i_dwell is sampled at peak entry; dwell=0 behaves as undefined.
//    o_peak_event pulses once, at entry only.
//  TRIWAVE_DWELL_EN undefined: no hold states, no i_dwell port, direct RISE<->FALL turnaround.
// STRUCTURE
//  Shared package hc_pkg: DATA_W default, tri_state_t encoding (IDLE/RISE/FALL/HOLD_HI/HOLD_LO),
//    SAT_MAX/SAT_MIN constants.
//  One sub-module: tri_step_clamp (combinational).
//    33-bit add/sub, compare against +/-amp, returns next sample + hit flag.
//  Top holds FSM, shadow registers, ready flag and dwell counter.
// TESTING
//  amp=10, step=3, enable: o_data 0,3,6,9,10*,7,4,1,-2,-5,-8,-10*,-7,-4,-1,2
//    (* = peak_event; pos=1 then 0).
//  Load amp=100, step=25 mid-FALL: o_ready=0 until edge -1->2; then 27,52,77,100*.
//  Second i_load while o_ready=0 (amp=5): ignored; peak stays 100 after apply.
//  amp=0x7FFFFFFF, step=0x40000000: no wrap; o_data hits 0x7FFFFFFF* then -0x7FFFFFFF*.
//  Drop i_enable for 8 cycles mid-RISE at o_data=6: o_data holds 6, no event;
//    resumes at 9 next enabled cycle.
//  Assert i_RESET=0 at o_data=-8 asynchronously: o_data=0, o_ready=1, IDLE before next clock edge.
//  TRIWAVE_DWELL_EN, dwell=3, amp=10, step=3: 9,10*,10,10,7 ...; -8,-10*,-10,-10,-7.

Source files
------------

// File: rtl/hc_pkg.sv
// Shared definitions for the triangle-wave source: default sample width,
// dwell counter width, FSM state encoding and signed saturation limits.
package hc_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int DWELL_W        = 16;

  // Largest legal magnitude; the most negative sample ever produced is SAT_MIN.
  localparam logic signed [DATA_W_DEFAULT-1:0] SAT_MAX = {1'b0, {(DATA_W_DEFAULT-1){1'b1}}};
  localparam logic signed [DATA_W_DEFAULT-1:0] SAT_MIN = -SAT_MAX;

  // HOLD_HI/HOLD_LO are only reachable when TRIWAVE_DWELL_EN is defined.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    FALL    = 3'd2,
    HOLD_HI = 3'd3,
    HOLD_LO = 3'd4
  } tri_state_t;

endpackage

// File: rtl/triangle_wave_gen_if.sv
// Control/sample bundle of the triangle-wave source.
// Optional i_dwell signal exists only when TRIWAVE_DWELL_EN is defined.
//
// Load handshake: an update is transferred on a rising clock edge where
// i_load && o_ready.  o_ready drops the cycle after a transfer and returns
// the cycle after the staged update becomes active.  i_load while o_ready
// is low is dropped, not queued.
interface triangle_wave_gen_if
  import hc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic                     i_enable;
  logic                     i_load;
  logic signed [DATA_W-1:0] i_amplitude;
  logic signed [DATA_W-1:0] i_step;
`ifdef TRIWAVE_DWELL_EN
  logic [DWELL_W-1:0]       i_dwell;
`endif
  logic                     o_ready;
  logic signed [DATA_W-1:0] o_data;
  logic                     o_peak_event;
  logic                     o_peak_positive;

  modport master (
    output i_enable, i_load, i_amplitude, i_step,
`ifdef TRIWAVE_DWELL_EN
    output i_dwell,
`endif
    input  o_ready, o_data, o_peak_event, o_peak_positive
  );

  modport slave (
    input  i_enable, i_load, i_amplitude, i_step,
`ifdef TRIWAVE_DWELL_EN
    input  i_dwell,
`endif
    output o_ready, o_data, o_peak_event, o_peak_positive
  );

endinterface

// File: rtl/tri_step_clamp.sv
// One step of the triangle: add or subtract the step in DATA_W+1 bits so
// nothing wraps, then clamp to +amp (rising) or -amp (falling) and flag it.
module tri_step_clamp #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] cur,
  input  logic signed [DATA_W-1:0] step,
  input  logic signed [DATA_W-1:0] amp,
  input  logic                     up,
  output logic signed [DATA_W-1:0] next_data,
  output logic                     hit
);

  logic signed [DATA_W:0] cur_x;
  logic signed [DATA_W:0] step_x;
  logic signed [DATA_W:0] amp_x;
  logic signed [DATA_W:0] sum;

  // Widened step and peak compare; step and amp are already non-negative.
  always_comb begin
    cur_x     = {cur[DATA_W-1], cur};
    step_x    = {1'b0, step};
    amp_x     = {1'b0, amp};
    sum       = up ? (cur_x + step_x) : (cur_x - step_x);
    hit       = up ? (sum >= amp_x) : (sum <= -amp_x);
    next_data = hit ? (up ? amp : -amp) : sum[DATA_W-1:0];
  end

endmodule

// File: rtl/triangle_wave_gen.sv
// Programmable symmetric triangle-wave source.  Staged amplitude/step
// updates take effect only at an upward zero crossing (or when leaving
// IDLE) so every period stays symmetric.
// Optional feature macro: TRIWAVE_DWELL_EN (hold at each peak for i_dwell cycles).
module triangle_wave_gen
  import hc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  triangle_wave_gen_if.slave bus,
  output tri_state_t         o_state
);

  tri_state_t               state_q;
  logic signed [DATA_W-1:0] data_q;
  logic                     peak_event_q;
  logic                     peak_pos_q;
  logic signed [DATA_W-1:0] amp_q;
  logic signed [DATA_W-1:0] step_q;
  logic signed [DATA_W-1:0] sh_amp_q;
  logic signed [DATA_W-1:0] sh_step_q;
  logic                     pending_q;
`ifdef TRIWAVE_DWELL_EN
  logic [DWELL_W-1:0]       dwell_q;
  logic                     in_hold;
`endif

  logic                     up;
  logic signed [DATA_W-1:0] nxt_data;
  logic                     hit;
  logic                     apply_now;
  logic signed [DATA_W-1:0] ld_amp;
  logic signed [DATA_W-1:0] ld_step;

  // Direction of the next computed sample; a hold phase resumes the opposite slope.
  always_comb begin
    up        = (state_q == RISE) || (state_q == HOLD_LO);
    ld_amp    = bus.i_amplitude[DATA_W-1] ? '0 : bus.i_amplitude;
    ld_step   = bus.i_step[DATA_W-1] ? '0 : bus.i_step;
    apply_now = pending_q && up && data_q[DATA_W-1] && !nxt_data[DATA_W-1];
`ifdef TRIWAVE_DWELL_EN
    in_hold   = (state_q == HOLD_HI) || (state_q == HOLD_LO);
`endif
  end

  tri_step_clamp #(.DATA_W(DATA_W)) u_step_clamp (
    .cur       (data_q),
    .step      (step_q),
    .amp       (amp_q),
    .up        (up),
    .next_data (nxt_data),
    .hit       (hit)
  );

  // Waveform FSM, load handshake and staged-update application.
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q      <= IDLE;
      data_q       <= '0;
      peak_event_q <= 1'b0;
      peak_pos_q   <= 1'b0;
      amp_q        <= '0;
      step_q       <= '0;
      sh_amp_q     <= '0;
      sh_step_q    <= '0;
      pending_q    <= 1'b0;
`ifdef TRIWAVE_DWELL_EN
      dwell_q      <= '0;
`endif
    end else begin
      peak_event_q <= 1'b0;
      // Capture and apply are mutually exclusive: one needs pending_q low, the other high.
      if (bus.i_load && !pending_q) begin
        sh_amp_q  <= ld_amp;
        sh_step_q <= ld_step;
        pending_q <= 1'b1;
      end
      if (bus.i_enable) begin
        if (state_q == IDLE) begin
          state_q <= RISE;
          data_q  <= '0;
          if (pending_q) begin
            amp_q     <= sh_amp_q;
            step_q    <= sh_step_q;
            pending_q <= 1'b0;
          end
        end
`ifdef TRIWAVE_DWELL_EN
        else if (in_hold && (dwell_q > DWELL_W'(1))) begin
          dwell_q <= dwell_q - DWELL_W'(1);
        end
`endif
        else begin
          data_q <= nxt_data;
          if (hit) begin
            peak_event_q <= 1'b1;
            peak_pos_q   <= up;
`ifdef TRIWAVE_DWELL_EN
            state_q      <= up ? HOLD_HI : HOLD_LO;
            dwell_q      <= bus.i_dwell;
`else
            state_q      <= up ? FALL : RISE;
`endif
          end else begin
            state_q <= up ? RISE : FALL;
          end
          // The sample on this edge already used the old step and amp.
          if (apply_now) begin
            amp_q     <= sh_amp_q;
            step_q    <= sh_step_q;
            pending_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.o_data          = data_q;
  assign bus.o_peak_event    = peak_event_q;
  assign bus.o_peak_positive = peak_pos_q;
  assign bus.o_ready         = ~pending_q;
  assign o_state             = state_q;

endmodule
